// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control path: opcodes, FSM states,
// ALU operand/operation selects and the bundled control word.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXEC_R    = 4'd2,
    S_EXEC_ADDR = 4'd3,
    S_EXEC_BR   = 4'd4,
    S_MEM_RD    = 4'd5,
    S_MEM_WR    = 4'd6,
    S_WB_R      = 4'd7,
    S_WB_LD     = 4'd8,
    S_TRAP      = 4'd9
  } state_t;

  typedef enum logic [1:0] {
    SRCB_REG  = 2'b00,
    SRCB_FOUR = 2'b01,
    SRCB_IMM  = 2'b10
  } alusrcb_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } aluop_t;

  typedef struct packed {
    logic     pc_write;
    logic     ir_write;
    logic     mem_read;
    logic     mem_write;
    logic     reg_write;
    logic     mem_to_reg;
    logic     iord;
    logic     alu_src_a;
    logic     pc_src;
    alusrcb_t alu_src_b;
    aluop_t   alu_op;
    logic     trap;
    logic     retire;
  } ctrl_t;

  // States that wait on the memory handshake and therefore run the timeout.
  function automatic logic is_mem_state(state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive stalled memory cycles; expired flags the timeout limit.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic count_en,
  input  logic clear,
  output logic expired
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)
      cnt_d = '0;
    else if (count_en && (cnt_q != 8'hFF))
      cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == 8'(MEM_TIMEOUT));

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle RISC-V control FSM: Moore decode off the registered state, with
// mem_ready/zero folded in only for the handshake-qualified strobes.
module multicycle_control_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       MemToReg,
  output logic       IorD,
  output logic       ALUSrcA,
  output logic       PCSrc,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUop,
  output logic       trap,
  output logic       retire,
  output logic [3:0] state
);

  state_t state_q, state_d;
  logic   expired;
  ctrl_t  c;

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait (
    .clk      (clk),
    .reset    (reset),
    .count_en (is_mem_state(state_q) && !mem_ready),
    .clear    (state_d != state_q),
    .expired  (expired)
  );

  // A handshake in the same cycle as the timeout wins over the trap.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:     if (mem_ready) state_d = S_DECODE;
                   else if (expired) state_d = S_TRAP;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:          state_d = S_EXEC_R;
          OP_LOAD, OP_STORE: state_d = S_EXEC_ADDR;
          OP_BRANCH:         state_d = S_EXEC_BR;
          default:           state_d = S_TRAP;
        endcase
      end
      S_EXEC_R:    state_d = S_WB_R;
      S_EXEC_ADDR: state_d = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      S_EXEC_BR:   state_d = S_FETCH;
      S_MEM_RD:    if (mem_ready) state_d = S_WB_LD;
                   else if (expired) state_d = S_TRAP;
      S_MEM_WR:    if (mem_ready) state_d = S_FETCH;
                   else if (expired) state_d = S_TRAP;
      S_WB_R,
      S_WB_LD:     state_d = S_FETCH;
      default:     state_d = S_TRAP;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    c = '0;
    case (state_q)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.ir_write  = mem_ready;
        c.pc_write  = mem_ready;
      end
      S_DECODE:    c.alu_src_b = SRCB_IMM;
      S_EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ALU_FUNCT;
      end
      S_EXEC_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
      end
      S_EXEC_BR: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ALU_SUB;
        c.pc_src    = 1'b1;
        c.pc_write  = zero;
        c.retire    = 1'b1;
      end
      S_MEM_RD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEM_WR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
        c.retire    = mem_ready;
      end
      S_WB_R: begin
        c.reg_write = 1'b1;
        c.retire    = 1'b1;
      end
      S_WB_LD: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        c.retire     = 1'b1;
      end
      S_TRAP:      c.trap = 1'b1;
      default:     c = '0;
    endcase
  end

  // Reset is asynchronous, so side-effecting strobes are masked combinationally.
  assign PCWrite  = c.pc_write  & ~reset;
  assign IRWrite  = c.ir_write  & ~reset;
  assign MemRead  = c.mem_read  & ~reset;
  assign MemWrite = c.mem_write & ~reset;
  assign RegWrite = c.reg_write & ~reset;
  assign retire   = c.retire    & ~reset;
  assign MemToReg = c.mem_to_reg;
  assign IorD     = c.iord;
  assign ALUSrcA  = c.alu_src_a;
  assign PCSrc    = c.pc_src;
  assign ALUSrcB  = c.alu_src_b;
  assign ALUop    = c.alu_op;
  assign trap     = c.trap;
  assign state    = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed vector table, hand-written reset/timeout corners, and random traffic
// checked against an instruction-plan reference model.
module tb_multicycle_control_fsm;
  import riscv_ctrl_pkg::*;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = OP_RTYPE;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, IRWrite, MemRead, MemWrite, RegWrite, MemToReg, IorD, ALUSrcA, PCSrc;
  logic [1:0] ALUSrcB, ALUop;
  logic       trap, retire;
  logic [3:0] state;

  multicycle_control_fsm #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .MemToReg(MemToReg), .IorD(IorD), .ALUSrcA(ALUSrcA),
    .PCSrc(PCSrc), .ALUSrcB(ALUSrcB), .ALUop(ALUop), .trap(trap), .retire(retire),
    .state(state)
  );

  always #5 clk = ~clk;

  // {PCWrite IRWrite MemRead MemWrite RegWrite MemToReg IorD ALUSrcA PCSrc ALUSrcB ALUop trap retire}
  logic [14:0] act;
  assign act = {PCWrite, IRWrite, MemRead, MemWrite, RegWrite, MemToReg, IorD,
                ALUSrcA, PCSrc, ALUSrcB, ALUop, trap, retire};

  localparam logic [14:0] O_FETCH_RDY  = 15'b1_1_1_0_0_0_0_0_0_01_00_0_0;
  localparam logic [14:0] O_FETCH_WAIT = 15'b0_0_1_0_0_0_0_0_0_01_00_0_0;
  localparam logic [14:0] O_DECODE     = 15'b0_0_0_0_0_0_0_0_0_10_00_0_0;
  localparam logic [14:0] O_EXEC_R     = 15'b0_0_0_0_0_0_0_1_0_00_10_0_0;
  localparam logic [14:0] O_EXEC_ADDR  = 15'b0_0_0_0_0_0_0_1_0_10_00_0_0;
  localparam logic [14:0] O_EXEC_BR    = 15'b0_0_0_0_0_0_0_1_1_00_01_0_1;
  localparam logic [14:0] O_MEM_RD     = 15'b0_0_1_0_0_0_1_0_0_00_00_0_0;
  localparam logic [14:0] O_MEM_WR     = 15'b0_0_0_1_0_0_1_0_0_00_00_0_0;
  localparam logic [14:0] O_WB_R       = 15'b0_0_0_0_1_0_0_0_0_00_00_0_1;
  localparam logic [14:0] O_WB_LD      = 15'b0_0_0_0_1_1_0_0_0_00_00_0_1;
  localparam logic [14:0] O_TRAP       = 15'b0_0_0_0_0_0_0_0_0_00_00_1_0;
  localparam logic [14:0] O_RESET      = 15'b0_0_0_0_0_0_0_0_0_01_00_0_0;
  localparam logic [14:0] B_PCW        = 15'b1_0_0_0_0_0_0_0_0_00_00_0_0;
  localparam logic [14:0] B_RET        = 15'b0_0_0_0_0_0_0_0_0_00_00_0_1;
  localparam logic [14:0] STROBES      = 15'b1_1_1_1_1_0_0_0_0_00_00_0_1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string what, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", what, got, exp, $time);
    end
  endtask

  // Drive at the falling edge, check once settled, leave the rising edge to act.
  task automatic apply_check(input logic [6:0] op, input logic z, input logic mr,
                             input state_t st, input logic [14:0] o, input string tag);
    @(negedge clk);
    opcode = op; zero = z; mem_ready = mr;
    #1;
    chk({tag, " state"}, 32'(state), 32'(st));
    chk({tag, " outs"}, 32'(act), 32'(o));
  endtask

  task automatic do_reset();
    @(negedge clk);
    mem_ready = 1'b0;
    reset = 1'b1;
    #1;
    chk("reset state", 32'(state), 32'(S_FETCH));
    chk("reset outs", 32'(act), 32'(O_RESET));
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  // Reference model: the current step plus the remaining plan of the instruction.
  state_t m_cur = S_FETCH;
  state_t m_plan[$];
  int     m_waits = 0;

  task automatic model_reset();
    m_cur = S_FETCH;
    m_plan.delete();
    m_waits = 0;
  endtask

  task automatic model_advance();
    if (m_cur == S_FETCH) begin
      m_plan.delete();
      m_plan.push_back(S_DECODE);
      if (opcode == OP_RTYPE) begin
        m_plan.push_back(S_EXEC_R); m_plan.push_back(S_WB_R);
      end else if (opcode == OP_LOAD) begin
        m_plan.push_back(S_EXEC_ADDR); m_plan.push_back(S_MEM_RD); m_plan.push_back(S_WB_LD);
      end else if (opcode == OP_STORE) begin
        m_plan.push_back(S_EXEC_ADDR); m_plan.push_back(S_MEM_WR);
      end else if (opcode == OP_BRANCH) begin
        m_plan.push_back(S_EXEC_BR);
      end else begin
        m_plan.push_back(S_TRAP);
      end
    end
    if (m_plan.size() == 0) m_cur = S_FETCH;
    else                    m_cur = m_plan.pop_front();
    m_waits = 0;
  endtask

  task automatic model_step();
    if (m_cur == S_TRAP) return;
    if (m_cur == S_FETCH || m_cur == S_MEM_RD || m_cur == S_MEM_WR) begin
      if (mem_ready)          model_advance();
      else if (m_waits == TO) begin m_cur = S_TRAP; m_waits = 0; end
      else                    m_waits++;
    end else begin
      model_advance();
    end
  endtask

  function automatic logic [14:0] exp_outs(state_t s, logic mr, logic z, logic rst);
    logic [14:0] o;
    case (s)
      S_FETCH:     o = mr ? O_FETCH_RDY : O_FETCH_WAIT;
      S_DECODE:    o = O_DECODE;
      S_EXEC_R:    o = O_EXEC_R;
      S_EXEC_ADDR: o = O_EXEC_ADDR;
      S_EXEC_BR:   o = z ? (O_EXEC_BR | B_PCW) : O_EXEC_BR;
      S_MEM_RD:    o = O_MEM_RD;
      S_MEM_WR:    o = mr ? (O_MEM_WR | B_RET) : O_MEM_WR;
      S_WB_R:      o = O_WB_R;
      S_WB_LD:     o = O_WB_LD;
      default:     o = O_TRAP;
    endcase
    if (rst) o = o & ~STROBES;
    return o;
  endfunction

  typedef struct {
    logic [6:0]  op;
    logic        z;
    logic        mr;
    state_t      st;
    logic [14:0] o;
  } vec_t;

  function automatic vec_t mk(logic [6:0] op, logic z, logic mr, state_t st, logic [14:0] o);
    vec_t v;
    v.op = op; v.z = z; v.mr = mr; v.st = st; v.o = o;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // R-type, mem_ready ignored outside memory states
    tbl.push_back(mk(OP_RTYPE, 0, 1, S_FETCH, O_FETCH_RDY));
    tbl.push_back(mk(OP_RTYPE, 0, 0, S_DECODE, O_DECODE));
    tbl.push_back(mk(OP_RTYPE, 0, 0, S_EXEC_R, O_EXEC_R));
    tbl.push_back(mk(OP_RTYPE, 0, 0, S_WB_R, O_WB_R));
    // load with three stalled MEM_RD cycles: 8 cycles total
    tbl.push_back(mk(OP_LOAD, 0, 1, S_FETCH, O_FETCH_RDY));
    tbl.push_back(mk(OP_LOAD, 0, 1, S_DECODE, O_DECODE));
    tbl.push_back(mk(OP_LOAD, 0, 1, S_EXEC_ADDR, O_EXEC_ADDR));
    tbl.push_back(mk(OP_LOAD, 0, 0, S_MEM_RD, O_MEM_RD));
    tbl.push_back(mk(OP_LOAD, 0, 0, S_MEM_RD, O_MEM_RD));
    tbl.push_back(mk(OP_LOAD, 0, 0, S_MEM_RD, O_MEM_RD));
    tbl.push_back(mk(OP_LOAD, 0, 1, S_MEM_RD, O_MEM_RD));
    tbl.push_back(mk(OP_LOAD, 0, 1, S_WB_LD, O_WB_LD));
    // store with a stalled fetch and a stalled write
    tbl.push_back(mk(OP_STORE, 0, 0, S_FETCH, O_FETCH_WAIT));
    tbl.push_back(mk(OP_STORE, 0, 1, S_FETCH, O_FETCH_RDY));
    tbl.push_back(mk(OP_STORE, 0, 1, S_DECODE, O_DECODE));
    tbl.push_back(mk(OP_STORE, 0, 1, S_EXEC_ADDR, O_EXEC_ADDR));
    tbl.push_back(mk(OP_STORE, 0, 0, S_MEM_WR, O_MEM_WR));
    tbl.push_back(mk(OP_STORE, 0, 1, S_MEM_WR, O_MEM_WR | B_RET));
    // branch taken, then not taken
    tbl.push_back(mk(OP_BRANCH, 1, 1, S_FETCH, O_FETCH_RDY));
    tbl.push_back(mk(OP_BRANCH, 1, 1, S_DECODE, O_DECODE));
    tbl.push_back(mk(OP_BRANCH, 1, 0, S_EXEC_BR, O_EXEC_BR | B_PCW));
    tbl.push_back(mk(OP_BRANCH, 0, 1, S_FETCH, O_FETCH_RDY));
    tbl.push_back(mk(OP_BRANCH, 0, 1, S_DECODE, O_DECODE));
    tbl.push_back(mk(OP_BRANCH, 0, 1, S_EXEC_BR, O_EXEC_BR));
    // illegal opcode traps and stays trapped
    tbl.push_back(mk(7'h7F, 0, 1, S_FETCH, O_FETCH_RDY));
    tbl.push_back(mk(7'h7F, 0, 1, S_DECODE, O_DECODE));
    tbl.push_back(mk(7'h7F, 1, 1, S_TRAP, O_TRAP));
    tbl.push_back(mk(7'h7F, 1, 0, S_TRAP, O_TRAP));
    tbl.push_back(mk(OP_RTYPE, 1, 1, S_TRAP, O_TRAP));

    do_reset();
    for (int i = 0; i < tbl.size(); i++)
      apply_check(tbl[i].op, tbl[i].z, tbl[i].mr, tbl[i].st, tbl[i].o, $sformatf("vec%0d", i));

    // fetch timeout: TO+1 stalled FETCH cycles, then TRAP
    do_reset();
    for (int k = 0; k <= TO; k++)
      apply_check(OP_RTYPE, 0, 0, S_FETCH, O_FETCH_WAIT, $sformatf("tmo wait%0d", k));
    apply_check(OP_RTYPE, 0, 1, S_TRAP, O_TRAP, "tmo trap");

    // handshake on the timeout cycle wins
    do_reset();
    for (int k = 0; k < TO; k++)
      apply_check(OP_RTYPE, 0, 0, S_FETCH, O_FETCH_WAIT, $sformatf("race wait%0d", k));
    apply_check(OP_RTYPE, 0, 1, S_FETCH, O_FETCH_RDY, "race hit");
    apply_check(OP_RTYPE, 0, 0, S_DECODE, O_DECODE, "race decode");

    // reset mid MEM_WR abandons the store without retiring
    do_reset();
    apply_check(OP_STORE, 0, 1, S_FETCH, O_FETCH_RDY, "rstwr fetch");
    apply_check(OP_STORE, 0, 1, S_DECODE, O_DECODE, "rstwr decode");
    apply_check(OP_STORE, 0, 1, S_EXEC_ADDR, O_EXEC_ADDR, "rstwr addr");
    apply_check(OP_STORE, 0, 0, S_MEM_WR, O_MEM_WR, "rstwr memwr");
    #2;
    mem_ready = 1'b1;
    reset = 1'b1;
    #1;
    chk("rstwr async state", 32'(state), 32'(S_FETCH));
    chk("rstwr async outs", 32'(act), 32'(O_RESET));
    @(posedge clk);
    #2;
    reset = 1'b0;
    apply_check(OP_STORE, 0, 1, S_FETCH, O_FETCH_RDY, "rstwr refetch");
    apply_check(OP_STORE, 0, 1, S_DECODE, O_DECODE, "rstwr redecode");

    // random traffic against the plan model
    do_reset();
    model_reset();
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      reset = ((m_cur == S_TRAP) && ($urandom_range(0, 3) == 0)) || ($urandom_range(0, 299) == 0);
      if (m_cur == S_FETCH) begin
        case ($urandom_range(0, 20))
          0:          opcode = 7'($urandom);
          1, 2, 3, 4: opcode = OP_RTYPE;
          5, 6, 7, 8, 9: opcode = OP_LOAD;
          10, 11, 12, 13, 14: opcode = OP_STORE;
          default:    opcode = OP_BRANCH;
        endcase
      end
      zero = 1'($urandom);
      mem_ready = ($urandom_range(0, 9) < 7);
      if (reset) model_reset();
      #1;
      chk("rand state", 32'(state), 32'(m_cur));
      chk("rand outs", 32'(act), 32'(exp_outs(m_cur, mem_ready, zero, reset)));
      @(posedge clk);
      if (!reset) model_step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
